// File: rtl/sonata_pkg.sv
// Board-level constants shared by the input pin conditioning logic.
// Pin indices, widths and reset levels for the dedicated input pins.
package sonata_pkg;

    localparam int IN_PIN_NUM = 5;
    localparam int IN_PIN_FILTER_CNT_WIDTH = 16;

    typedef logic [IN_PIN_NUM-1:0] sonata_in_pins_t;

    // Serial lines idle high, so every pin resets to 1.
    localparam sonata_in_pins_t IN_PIN_RESET_VAL = '1;

    localparam int IN_PIN_SER0_RX  = 0;
    localparam int IN_PIN_SER1_RX  = 1;
    localparam int IN_PIN_RS232_RX = 2;
    localparam int IN_PIN_MB_RX    = 3;
    localparam int IN_PIN_MB_INT   = 4;

endpackage

// File: rtl/in_pin_filter_chan.sv
// Single-pin slice: two-flop synchroniser, stability filter,
// and sticky rise/fall event flag.
module in_pin_filter_chan #(
    parameter int unsigned CntWidth = 16,
    parameter logic        ResetVal = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                pin_i,
    input  logic                filter_en_i,
    input  logic [CntWidth-1:0] filter_cycles_i,
    input  logic                rise_en_i,
    input  logic                fall_en_i,
    input  logic                event_clr_i,
    output logic                pin_o,
    output logic                event_o
);

    logic                r_sync1;
    logic                r_sync2;
    logic [1:0]          r_vld;
    logic                r_armed;
    logic                r_filt;
    logic [CntWidth-1:0] r_cnt;
    logic                r_event;

    logic                w_filt_d;
    logic [CntWidth-1:0] w_cnt_d;
    logic                w_set;
    logic                w_event_d;
    logic                w_armed_d;

    // Two-flop synchroniser; r_vld marks when real pad data has reached r_sync2.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= ResetVal;
            r_sync2 <= ResetVal;
            r_vld   <= '0;
        end else begin
            r_sync1 <= pin_i;
            r_sync2 <= r_sync1;
            r_vld   <= {r_vld[0], 1'b1};
        end
    end

    // Filter: accept the synced level once it has differed for the threshold.
    always_comb begin
        w_filt_d = r_filt;
        w_cnt_d  = '0;
        if (!filter_en_i) begin
            w_filt_d = r_sync2;
        end else if (r_sync2 != r_filt) begin
            if (r_cnt >= filter_cycles_i) begin
                w_filt_d = r_sync2;
            end else if (r_cnt != '1) begin
                w_cnt_d = r_cnt + 1'b1;
            end else begin
                w_cnt_d = r_cnt;
            end
        end
    end

    // Events stay masked until the filter has first taken the real pad level,
    // so the settling after reset release never raises a flag.
    always_comb begin
        w_armed_d = r_armed | (r_vld[1] & (w_filt_d == r_sync2));
        w_set     = r_armed &
                    ((~r_filt &  w_filt_d & rise_en_i) |
                     ( r_filt & ~w_filt_d & fall_en_i));
        w_event_d = (r_event & ~event_clr_i) | w_set;
    end

    // Filtered level, mismatch counter and sticky event state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_filt  <= ResetVal;
            r_cnt   <= '0;
            r_event <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_filt  <= w_filt_d;
            r_cnt   <= w_cnt_d;
            r_event <= w_event_d;
            r_armed <= w_armed_d;
        end
    end

    assign pin_o   = r_filt;
    assign event_o = r_event;

endmodule

// File: rtl/in_pin_filter.sv
// Input pin conditioning: one filter channel per pin, with the
// sticky event flags combined into a single interrupt.
module in_pin_filter
    import sonata_pkg::*;
#(
    parameter int unsigned        NumPins  = IN_PIN_NUM,
    parameter int unsigned        CntWidth = IN_PIN_FILTER_CNT_WIDTH,
    parameter logic [NumPins-1:0] ResetVal = NumPins'(IN_PIN_RESET_VAL)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumPins-1:0]  pins_i,
    input  logic [NumPins-1:0]  filter_en_i,
    input  logic [CntWidth-1:0] filter_cycles_i,
    input  logic [NumPins-1:0]  rise_en_i,
    input  logic [NumPins-1:0]  fall_en_i,
    input  logic [NumPins-1:0]  event_clr_i,
    output logic [NumPins-1:0]  pins_o,
    output logic [NumPins-1:0]  event_o,
    output logic                irq_o
);

    for (genvar g = 0; g < NumPins; g++) begin : g_chan
        in_pin_filter_chan #(
            .CntWidth (CntWidth),
            .ResetVal (ResetVal[g])
        ) u_chan (
            .clk_i           (clk_i),
            .rst_ni          (rst_ni),
            .pin_i           (pins_i[g]),
            .filter_en_i     (filter_en_i[g]),
            .filter_cycles_i (filter_cycles_i),
            .rise_en_i       (rise_en_i[g]),
            .fall_en_i       (fall_en_i[g]),
            .event_clr_i     (event_clr_i[g]),
            .pin_o           (pins_o[g]),
            .event_o         (event_o[g])
        );
    end

    // Interrupt is a pure OR of registered flags.
    always_comb begin
        irq_o = |event_o;
    end

endmodule
